// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - ping-pong frame sequencer feeding a 64-point SDF FFT
module fft_frame_ctrl #(
  parameter int WIDTH      = 32,
  parameter int LOG_N      = 6,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  output logic             fft_in_en,
  output logic [WIDTH-1:0] fft_in_re,
  output logic [WIDTH-1:0] fft_in_im,
  input  logic             fft_out_en,
  output logic             frame_done,
  output logic [7:0]       frame_idx,
  output logic [1:0]       in_flight,
  output logic             err
);

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST     = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] ONE      = LOG_N'(1);
  localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  // Two frame banks, each word packs {re, im}
  logic [2*WIDTH-1:0] mem0 [N];
  logic [2*WIDTH-1:0] mem1 [N];
  logic [2*WIDTH-1:0] rd_word;

  logic [1:0]       full;
  logic             wr_bank;
  logic [LOG_N-1:0] wr_cnt;

  state_t           state, state_n;
  logic             rd_bank, rd_bank_n;
  logic [LOG_N-1:0] rd_cnt, rd_cnt_n;
  logic [3:0]       gap_cnt, gap_cnt_n;

  logic             accept, wr_last, rd_last, burst_start;
  logic             issue_point, issue_ok, issue_blocked;

  logic [LOG_N-1:0] out_cnt;
  logic             out_en_q;
  logic             out_wrap;

  // Ready is withheld while reset is high and whenever the bank being filled is still waiting to drain
  assign s_ready     = ~reset & ~full[wr_bank];
  assign accept      = s_valid & s_ready;
  assign wr_last     = accept && (wr_cnt == LAST);
  assign rd_last     = (state == BURST) && (rd_cnt == LAST);
  assign burst_start = (state == BURST) && (rd_cnt == '0);

  // A new burst may begin from IDLE or on the final GAP cycle; a full FFT pipeline blocks it
  assign issue_point   = (state == IDLE) || ((state == GAP) && (gap_cnt <= 4'd1));
  assign issue_ok      = full[rd_bank] && (in_flight != 2'd3);
  assign issue_blocked = issue_point && full[rd_bank] && (in_flight == 2'd3);

  assign rd_word  = rd_bank ? mem1[rd_cnt] : mem0[rd_cnt];
  assign out_wrap = fft_out_en && (out_cnt == LAST);

  assign frame_done = ~reset & out_wrap;

  // Sample storage: synchronous write into the bank currently being filled
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_bank) mem1[wr_cnt] <= {s_re, s_im};
      else         mem0[wr_cnt] <= {s_re, s_im};
    end
  end

  // Write pointer: advance per accepted sample, switch banks on frame completion
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + ONE;
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  // Bank-full flags: fill and drain of opposite banks may land in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_last && (wr_bank == b[0]))      full[b] <= 1'b1;
        else if (rd_last && (rd_bank == b[0])) full[b] <= 1'b0;
      end
    end
  end

  // Issue FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      rd_bank <= rd_bank_n;
      rd_cnt  <= rd_cnt_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // Issue FSM next state: IDLE waits for a full bank, BURST streams 64 reads, GAP enforces spacing
  always_comb begin
    state_n   = state;
    rd_bank_n = rd_bank;
    rd_cnt_n  = rd_cnt;
    gap_cnt_n = gap_cnt;
    case (state)
      IDLE: begin
        if (issue_ok) begin
          state_n  = BURST;
          rd_cnt_n = '0;
        end
      end
      BURST: begin
        rd_cnt_n = rd_cnt + ONE;
        if (rd_last) begin
          state_n   = GAP;
          gap_cnt_n = GAP_LOAD;
          rd_bank_n = ~rd_bank;
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) begin
          gap_cnt_n = '0;
          if (issue_ok) begin
            state_n  = BURST;
            rd_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FFT input drive: registered read aligned with the enable, zeroed outside bursts
  always_ff @(posedge clk) begin
    if (reset) begin
      fft_in_en <= 1'b0;
      fft_in_re <= '0;
      fft_in_im <= '0;
    end else begin
      fft_in_en <= (state == BURST);
      if (state == BURST) begin
        fft_in_re <= rd_word[2*WIDTH-1:WIDTH];
        fft_in_im <= rd_word[WIDTH-1:0];
      end else begin
        fft_in_re <= '0;
        fft_in_im <= '0;
      end
    end
  end

  // Output tracking: frame counting, in-flight accounting and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt   <= '0;
      out_en_q  <= 1'b0;
      frame_idx <= 8'd0;
      in_flight <= 2'd0;
      err       <= 1'b0;
    end else begin
      out_en_q <= fft_out_en;
      if (fft_out_en) out_cnt <= out_cnt + ONE;
      if (out_wrap) frame_idx <= frame_idx + 8'd1;

      if (burst_start && !(out_wrap && (in_flight != 2'd0))) begin
        in_flight <= in_flight + 2'd1;
      end else if (!burst_start && out_wrap && (in_flight != 2'd0)) begin
        in_flight <= in_flight - 2'd1;
      end

      if ((fft_out_en && (in_flight == 2'd0)) ||
          (out_en_q && !fft_out_en && (out_cnt != '0)) ||
          issue_blocked) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed self-checking bench for fft_frame_ctrl
module tb_fft_frame_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_re = '0;
  logic [WIDTH-1:0] s_im = '0;
  logic             fft_in_en;
  logic [WIDTH-1:0] fft_in_re;
  logic [WIDTH-1:0] fft_in_im;
  logic             fft_out_en;
  logic             frame_done;
  logic [7:0]       frame_idx;
  logic [1:0]       in_flight;
  logic             err;

  logic             stub_en = 1'b1;
  logic             man_en = 1'b0;
  logic [LAT-1:0]   stub_sr = '0;

  int checks = 0;
  int errors = 0;

  fft_frame_ctrl #(.WIDTH(WIDTH), .LOG_N(6), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_re       (s_re),
    .s_im       (s_im),
    .fft_in_en  (fft_in_en),
    .fft_in_re  (fft_in_re),
    .fft_in_im  (fft_in_im),
    .fft_out_en (fft_out_en),
    .frame_done (frame_done),
    .frame_idx  (frame_idx),
    .in_flight  (in_flight),
    .err        (err)
  );

  always #5 clk = ~clk;

  // FFT stub: output enable is the input enable delayed by a fixed latency
  always @(posedge clk) stub_sr <= reset ? '0 : {stub_sr[LAT-2:0], fft_in_en};
  assign fft_out_en = stub_en ? stub_sr[LAT-1] : man_en;

  // Monitor: capture burst data, burst lengths, idle gaps and completed frames
  int cyc = 0, run_len = 0, idle_len = 0, zero_bad = 0;
  bit have_prev = 0;
  int bursts_q[$], gaps_q[$], starts_q[$], done_q[$];
  logic [63:0] got_q[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      run_len = 0;
      idle_len = 0;
      have_prev = 0;
    end else begin
      if (fft_in_en) begin
        if (run_len == 0) begin
          starts_q.push_back(cyc);
          if (have_prev) gaps_q.push_back(idle_len);
        end
        got_q.push_back({fft_in_re, fft_in_im});
        run_len++;
      end else begin
        if (run_len != 0) begin
          bursts_q.push_back(run_len);
          have_prev = 1;
          idle_len = 0;
        end
        run_len = 0;
        idle_len++;
        if (fft_in_re != '0 || fft_in_im != '0) zero_bad++;
      end
      if (frame_done) done_q.push_back(int'(frame_idx));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic send(input int base, input int n, input bit rnd,
                      output int stalls, output int last_acc);
    int k = 0;
    int budget = 0;
    stalls = 0;
    last_acc = 0;
    while (k < n && budget < 20000) begin
      @(negedge clk);
      budget++;
      s_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_re = 32'(base + k);
      s_im = 32'(-(base + k));
      #1;
      if (s_valid && !s_ready) stalls++;
      if (s_valid && s_ready) begin
        last_acc = cyc;
        k++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("send_count", 64'(k), 64'(n));
  endtask

  task automatic wait_bursts(input int target);
    int b = 0;
    while (bursts_q.size() < target && b < 3000) begin
      @(negedge clk);
      #2;
      b++;
    end
    check("wait_bursts", 64'(bursts_q.size() >= target), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int b = 0;
    while (done_q.size() < target && b < 3000) begin
      @(negedge clk);
      #2;
      b++;
    end
    check("wait_done", 64'(done_q.size() >= target), 64'd1);
  endtask

  task automatic check_data(input string tag, input int g0, input int base, input int n);
    int bad = 0;
    logic [31:0] r, i;
    for (int k = 0; k < n; k++) begin
      r = 32'(base + k);
      i = 32'(-(base + k));
      if (g0 + k >= got_q.size()) bad++;
      else if (got_q[g0 + k] !== {r, i}) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, la, g0, b0, s0, gq, d0, bad, w;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_fft_in_en", 64'(fft_in_en), 64'd0);
    check("rst_in_flight", 64'(in_flight), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    check("post_rst_frame_idx", 64'(frame_idx), 64'd0);
    check("post_rst_fft_in_re", 64'(fft_in_re), 64'd0);

    // Test 1: single frame with continuous valid
    g0 = got_q.size(); b0 = bursts_q.size(); s0 = starts_q.size();
    send(0, 64, 1'b0, st, la);
    check("t1_stalls", 64'(st), 64'd0);
    wait_bursts(b0 + 1);
    check("t1_burst_len", 64'(bursts_q[b0]), 64'd64);
    check("t1_latency_ge2", 64'((starts_q[s0] - la) >= 2), 64'd1);
    check_data("t1_data", g0, 0, 64);
    wait_done(1);
    check("t1_frame_idx", 64'(done_q[0]), 64'd0);

    // Test 2: three frames back to back
    g0 = got_q.size(); b0 = bursts_q.size(); gq = gaps_q.size();
    send(100, 192, 1'b0, st, la);
    check("t2_stalls", 64'(st), 64'd1);
    wait_bursts(b0 + 3);
    for (int j = 0; j < 3; j++) check("t2_burst_len", 64'(bursts_q[b0 + j]), 64'd64);
    check("t2_gap1", 64'(gaps_q[gq + 1]), 64'd2);
    check("t2_gap2", 64'(gaps_q[gq + 2]), 64'd2);
    check_data("t2_data", g0, 100, 192);

    // Test 3: completion tracking
    wait_done(4);
    for (int j = 1; j < 4; j++) check("t3_frame_idx", 64'(done_q[j]), 64'(j));
    repeat (20) @(negedge clk);
    #1;
    check("t3_in_flight", 64'(in_flight), 64'd0);
    check("t3_err", 64'(err), 64'd0);
    check("t3_zero_idle", 64'(zero_bad), 64'd0);

    // Test 4: spurious output enable with nothing in flight
    stub_en = 1'b0;
    man_en = 1'b1;
    @(negedge clk);
    #1;
    check("t4_err_set", 64'(err), 64'd1);
    repeat (9) @(negedge clk);
    man_en = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("t4_err_sticky", 64'(err), 64'd1);

    // Test 5: reset in the middle of a burst
    reset = 1'b1;
    stub_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_err_cleared", 64'(err), 64'd0);
    send(1000, 64, 1'b0, st, la);
    w = 0;
    while (run_len < 20 && w < 500) begin
      @(negedge clk);
      #2;
      w++;
    end
    check("t5_reached_mid", 64'(run_len >= 20), 64'd1);
    check("t5_in_flight_mid", 64'(in_flight), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t5_en_abort", 64'(fft_in_en), 64'd0);
    check("t5_in_flight_rst", 64'(in_flight), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_s_ready", 64'(s_ready), 64'd1);
    g0 = got_q.size(); b0 = bursts_q.size(); d0 = done_q.size();
    send(2000, 64, 1'b0, st, la);
    wait_bursts(b0 + 1);
    check("t5_burst_len", 64'(bursts_q[b0]), 64'd64);
    check_data("t5_data", g0, 2000, 64);
    wait_done(d0 + 1);
    check("t5_frame_idx", 64'(done_q[d0]), 64'd0);

    // Test 6: random valid over ten frames
    g0 = got_q.size(); b0 = bursts_q.size(); d0 = done_q.size();
    send(3000, 640, 1'b1, st, la);
    wait_bursts(b0 + 10);
    bad = 0;
    for (int j = 0; j < 10; j++) if (bursts_q[b0 + j] != 64) bad++;
    check("t6_burst_lens", 64'(bad), 64'd0);
    check_data("t6_data", g0, 3000, 640);
    wait_done(d0 + 10);
    check("t6_last_frame_idx", 64'(done_q[d0 + 9]), 64'd10);
    repeat (20) @(negedge clk);
    #1;
    check("t6_in_flight", 64'(in_flight), 64'd0);
    check("t6_err", 64'(err), 64'd0);
    check("t6_zero_idle", 64'(zero_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
